// File: rtl/data_mem_arb_pkg.sv
// Shared types and widths for the two-port data-memory arbiter.
package data_mem_arb_pkg;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int NUM_PORTS = 2;
  // Wide enough for any MAX_LOCK in 1..15
  localparam int CNT_W     = 4;

  typedef logic port_idx_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              p0_req, p0_we, p0_lock;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt, p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req, p1_we, p1_lock;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt, p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_address, mem_write_data, mem_read, mem_write,
    input  mem_read_data
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_address, mem_write_data, mem_read, mem_write,
    output mem_read_data
  );
endinterface

// File: rtl/data_mem_rr_picker.sv
// Combinational grant selection: lock hold, lock limit, then round-robin.
module data_mem_rr_picker
  import data_mem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_idx_t            ptr_i,
  input  port_idx_t            owner_i,
  input  logic [CNT_W-1:0]     lock_cnt_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output port_idx_t            gnt_idx_o
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_LOCK);

  logic hold, at_lim;

  always_comb begin
    hold      = (lock_cnt_i != '0) && (lock_cnt_i < LIM) && req_i[owner_i];
    at_lim    = (lock_cnt_i == LIM) && req_i[~owner_i];
    gnt_idx_o = ptr_i;
    if (hold)          gnt_idx_o = owner_i;
    else if (at_lim)   gnt_idx_o = ~owner_i;
    else if (&req_i)   gnt_idx_o = ptr_i;
    else if (req_i[1]) gnt_idx_o = 1'b1;
    else               gnt_idx_o = 1'b0;
    gnt_o = '0;
    if (|req_i) gnt_o[gnt_idx_o] = 1'b1;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one 256x16 memory port between two requesters, one access per cycle,
// and returns registered read data to the port that issued the read.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 4
) (
  input logic              clk,
  input logic              reset,
  data_mem_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_LOCK);

  mem_req_t [NUM_PORTS-1:0] prt;
  mem_req_t                 sel;
  logic [NUM_PORTS-1:0]     req_v, pick_gnt, gnt;
  port_idx_t                gidx;
  logic                     any_gnt;

  port_idx_t                              ptr_q, ptr_d, owner_q, owner_d;
  logic [CNT_W-1:0]                       lock_cnt_q, lock_cnt_d;
  logic [NUM_PORTS-1:0]                   rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wdata_o;
  logic              rd_o, wr_o;

  assign prt[0] = '{req: bus.p0_req, we: bus.p0_we, lock: bus.p0_lock,
                    addr: bus.p0_addr, wdata: bus.p0_wdata};
  assign prt[1] = '{req: bus.p1_req, we: bus.p1_we, lock: bus.p1_lock,
                    addr: bus.p1_addr, wdata: bus.p1_wdata};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
    assign req_v[i] = prt[i].req;
  end

  data_mem_rr_picker #(.MAX_LOCK(MAX_LOCK)) u_pick (
    .req_i      (req_v),
    .ptr_i      (ptr_q),
    .owner_i    (owner_q),
    .lock_cnt_i (lock_cnt_q),
    .gnt_o      (pick_gnt),
    .gnt_idx_o  (gidx)
  );

  // Reset gates the grant combinationally so a write in flight never strobes.
  assign gnt     = pick_gnt & {NUM_PORTS{~reset}};
  assign any_gnt = |gnt;
  assign sel     = prt[gidx];

  always_comb begin
    addr_o  = '0;
    wdata_o = '0;
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    if (any_gnt) begin
      addr_o  = sel.addr;
      wdata_o = sel.wdata;
      wr_o    = sel.we;
      rd_o    = ~sel.we;
    end
  end

  // A nonzero count implies the previous cycle granted owner, so a repeat
  // grant to owner always continues the run.
  always_comb begin
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    if (any_gnt) begin
      ptr_d   = ~gidx;
      owner_d = gidx;
      if (sel.lock)
        lock_cnt_d = (gidx != owner_q) ? CNT_W'(1) :
                     (lock_cnt_q == LIM) ? LIM : lock_cnt_q + CNT_W'(1);
      if (!sel.we) begin
        rvalid_d[gidx] = 1'b1;
        rdata_d[gidx]  = bus.mem_read_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.mem_address    = addr_o;
  assign bus.mem_write_data = wdata_o;
  assign bus.mem_read       = rd_o;
  assign bus.mem_write      = wr_o;
  assign bus.p0_gnt         = gnt[0];
  assign bus.p1_gnt         = gnt[1];
  assign bus.p0_rvalid      = rvalid_q[0];
  assign bus.p1_rvalid      = rvalid_q[1];
  assign bus.p0_rdata       = rdata_q[0];
  assign bus.p1_rdata       = rdata_q[1];
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 256x16 memory model.
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_arbiter_if bus ();
  data_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Memory model: unwritten words read as 0xC000 | addr.
  logic [15:0]  mem [256];
  logic [255:0] wr_seen = '0;
  function automatic logic [15:0] initv(logic [7:0] a);
    return 16'hC000 | {8'h00, a};
  endfunction
  always @(posedge clk)
    if (bus.mem_write) begin
      mem[bus.mem_address]     <= bus.mem_write_data;
      wr_seen[bus.mem_address] <= 1'b1;
    end
  assign bus.mem_read_data = !bus.mem_read ? 16'hDEAD :
                             wr_seen[bus.mem_address] ? mem[bus.mem_address] :
                             initv(bus.mem_address);

  int n_chk = 0, n_fail = 0;
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drv0(logic r, logic we, logic lk, logic [7:0] a, logic [15:0] d);
    bus.p0_req = r; bus.p0_we = we; bus.p0_lock = lk; bus.p0_addr = a; bus.p0_wdata = d;
  endtask
  task automatic drv1(logic r, logic we, logic lk, logic [7:0] a, logic [15:0] d);
    bus.p1_req = r; bus.p1_we = we; bus.p1_lock = lk; bus.p1_addr = a; bus.p1_wdata = d;
  endtask

  logic [7:0]  a0, a1;
  logic [15:0] last1;
  int          ep;

  initial begin
    // Reset with both ports requesting
    reset = 1'b1;
    a0 = 8'h01; a1 = 8'h02;
    drv0(1, 0, 0, a0, 16'h0);
    drv1(1, 0, 0, a1, 16'h0);
    #2;
    check("rst_gnt0",   bus.p0_gnt, 0);
    check("rst_gnt1",   bus.p1_gnt, 0);
    check("rst_rvalid", {bus.p0_rvalid, bus.p1_rvalid}, 0);
    check("rst_rdata0", bus.p0_rdata, 0);
    check("rst_rdata1", bus.p1_rdata, 0);
    check("rst_mem",    {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data}, 0);

    // Round-robin reads; p0 wins first after reset
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      ep = k % 2;
      check("rr_gnt0", bus.p0_gnt, ep == 0);
      check("rr_gnt1", bus.p1_gnt, ep == 1);
      check("rr_addr", bus.mem_address, ep == 0 ? a0 : a1);
      @(negedge clk);
      check("rr_rvalid0", bus.p0_rvalid, ep == 0);
      check("rr_rvalid1", bus.p1_rvalid, ep == 1);
      check("rr_rdata", ep == 0 ? bus.p0_rdata : bus.p1_rdata, initv(ep == 0 ? a0 : a1));
      if (ep == 0) begin a0 = a0 + 8'd2; bus.p0_addr = a0; end
      else begin last1 = initv(a1); a1 = a1 + 8'd2; bus.p1_addr = a1; end
    end

    // Idle: all memory outputs zero
    bus.p0_req = 0; bus.p1_req = 0;
    #1;
    check("idle_gnt", {bus.p0_gnt, bus.p1_gnt}, 0);
    check("idle_mem", {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data}, 0);

    // Write then read back on p0
    @(negedge clk); drv0(1, 1, 0, 8'h12, 16'hBEEF);
    #1;
    check("wr_gnt0",  bus.p0_gnt, 1);
    check("wr_strb",  {bus.mem_write, bus.mem_read}, 2'b10);
    check("wr_data",  bus.mem_write_data, 16'hBEEF);
    @(negedge clk);
    check("wr_norsp", bus.p0_rvalid, 0);
    drv0(1, 0, 0, 8'h12, 16'h0);
    #1;
    check("rd_gnt0",  bus.p0_gnt, 1);
    check("rd_strb",  {bus.mem_write, bus.mem_read}, 2'b01);
    @(negedge clk);
    bus.p0_req = 0;
    check("raw_rvalid0", bus.p0_rvalid, 1);
    check("raw_rdata0",  bus.p0_rdata, 16'hBEEF);
    check("raw_rvalid1", bus.p1_rvalid, 0);
    check("raw_rdata1_hold", bus.p1_rdata, last1);

    // Lone p1 read; leaves ptr on p0
    drv1(1, 0, 0, 8'h05, 16'h0);
    #1;
    check("lone_gnt1", bus.p1_gnt, 1);
    @(negedge clk);
    check("lone_rdata1", {bus.p1_rvalid, bus.p1_rdata}, {1'b1, initv(8'h05)});

    // Lock limit: p0 locked, p1 waiting from cycle 0
    drv0(1, 0, 1, 8'h20, 16'h0);
    drv1(1, 0, 0, 8'h30, 16'h0);
    for (int c = 0; c < 6; c++) begin
      #1;
      check("lock_gnt0", bus.p0_gnt, c != 4);
      check("lock_gnt1", bus.p1_gnt, c == 4);
      @(negedge clk);
      if (c == 4) bus.p1_req = 0;
    end

    // Lock with p1 idle for 10 cycles, then p1 wins at saturation
    bus.p0_req = 0;
    @(negedge clk);
    bus.p0_req = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("lkidle_gnt0", bus.p0_gnt, 1);
      @(negedge clk);
    end
    drv1(1, 0, 0, 8'h31, 16'h0);
    #1;
    check("lksat_gnt1", bus.p1_gnt, 1);
    check("lksat_gnt0", bus.p0_gnt, 0);
    @(negedge clk);
    drv0(0, 0, 0, 8'h00, 16'h0);
    drv1(0, 0, 0, 8'h00, 16'h0);

    // Reset during a p1 write while a p0 read response is pending
    @(negedge clk); drv0(1, 0, 0, 8'h41, 16'h0);
    @(negedge clk);
    bus.p0_req = 0;
    drv1(1, 1, 0, 8'h40, 16'h5555);
    #1;
    check("mid_pre_wr",  {bus.p1_gnt, bus.mem_write, bus.p0_rvalid}, 3'b111);
    #1; reset = 1'b1;
    #1;
    check("mid_wr_drop", {bus.p1_gnt, bus.mem_write, bus.p0_rvalid}, 3'b000);
    check("mid_addr",    bus.mem_address, 0);
    @(negedge clk);
    reset = 1'b0; bus.p1_req = 0;
    #1;
    check("mid_mem40",   wr_seen[8'h40] ? mem[8'h40] : initv(8'h40), initv(8'h40));
    check("mid_norv",    {bus.p0_rvalid, bus.p1_rvalid}, 0);
    @(negedge clk);
    check("mid_norv2",   {bus.p0_rvalid, bus.p1_rvalid}, 0);
    check("mid_rdata0",  bus.p0_rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
